// File: rtl/serial_tx.sv
// UART-style framed serial transmitter: idle-high line, start bit, DATA_W data
// bits LSB-first, optional even parity, one stop bit, each bit held CLKS_PER_BIT clocks.
module serial_tx #(
  parameter int unsigned DATA_W       = 8,
  parameter int unsigned CLKS_PER_BIT = 4,
  parameter bit          PARITY_EN    = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              tx,
  output logic              busy,
  output logic              done
);

  localparam int unsigned CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int unsigned BIT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_W - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_e;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  clk_cnt_q, clk_cnt_d;
  logic [BIT_W-1:0]  bit_cnt_q, bit_cnt_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic              parity_q, parity_d;
  logic              tx_q, tx_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              bit_end;

  assign bit_end  = (clk_cnt_q == CNT_LAST);
  assign in_ready = (state_q == S_IDLE);
  assign tx       = tx_q;
  assign busy     = busy_q;
  assign done     = done_q;

  // NOTE: every *_d gets a default before the case so no path leaves one unassigned (no latches).
  always_comb begin
    state_d   = state_q;
    clk_cnt_d = clk_cnt_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    parity_d  = parity_q;
    tx_d      = tx_q;
    busy_d    = busy_q;
    done_d    = 1'b0;

    if (state_q != S_IDLE) begin
      clk_cnt_d = bit_end ? '0 : clk_cnt_q + 1'b1;
    end

    unique case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          state_d   = S_START;
          shift_d   = in_data;
          parity_d  = ^in_data;
          tx_d      = 1'b0;
          busy_d    = 1'b1;
          clk_cnt_d = '0;
          bit_cnt_d = '0;
        end
      end
      S_START: begin
        if (bit_end) begin
          state_d   = S_DATA;
          tx_d      = shift_q[0];
          shift_d   = shift_q >> 1;
          bit_cnt_d = '0;
        end
      end
      S_DATA: begin
        if (bit_end) begin
          if (bit_cnt_q == BIT_LAST) begin
            bit_cnt_d = '0;
            if (PARITY_EN) begin
              state_d = S_PARITY;
              tx_d    = parity_q;
            end else begin
              state_d = S_STOP;
              tx_d    = 1'b1;
            end
          end else begin
            // The next data bit always sits in shift_q[0]; shifting here keeps DATA_W=1 legal.
            bit_cnt_d = bit_cnt_q + 1'b1;
            tx_d      = shift_q[0];
            shift_d   = shift_q >> 1;
          end
        end
      end
      S_PARITY: begin
        if (bit_end) begin
          state_d = S_STOP;
          tx_d    = 1'b1;
        end
      end
      S_STOP: begin
        if (bit_end) begin
          state_d = S_IDLE;
          tx_d    = 1'b1;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
        tx_d    = 1'b1;
        busy_d  = 1'b0;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      clk_cnt_q <= '0;
      bit_cnt_q <= '0;
      shift_q   <= '0;
      parity_q  <= 1'b0;
      tx_q      <= 1'b1;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      clk_cnt_q <= clk_cnt_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      parity_q  <= parity_d;
      tx_q      <= tx_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

endmodule

// File: tb/tb_serial_tx.sv
// Self-checking bench for serial_tx: frame-level reference model compared every
// cycle, plus hand-computed line sequences for the directed frames.
module tb_serial_tx;

  localparam int DW    = 8;
  localparam int CPB   = 4;
  localparam int PE    = 1;
  localparam int NB    = 2 + DW + PE;
  localparam int FRAME = NB * CPB;

  logic          clk      = 1'b0;
  logic          rst      = 1'b1;
  logic          in_valid = 1'b0;
  logic [DW-1:0] in_data  = '0;
  logic          in_ready, tx, busy, done;

  int errors = 0;
  int checks = 0;

  serial_tx #(
    .DATA_W      (DW),
    .CLKS_PER_BIT(CPB),
    .PARITY_EN   (1'b1)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .in_data (in_data),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .tx      (tx),
    .busy    (busy),
    .done    (done)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a frame is a list of line bits, each lasting CPB cycles.
  int   m_rem  = 0;
  int   m_pos  = 0;
  logic m_done = 1'b0;
  logic m_bits [NB];
  bit   chk_en = 1'b0;

  always @(posedge clk) begin
    if (rst) begin
      m_rem  = 0;
      m_pos  = 0;
      m_done = 1'b0;
      chk_en = 1'b1;
    end else if (m_rem > 0) begin
      m_rem--;
      m_pos++;
      m_done = (m_rem == 0);
    end else begin
      m_done = 1'b0;
      if (in_valid) begin
        m_bits[0] = 1'b0;
        for (int i = 0; i < DW; i++) m_bits[1+i] = in_data[i];
        if (PE != 0) m_bits[1+DW] = ^in_data;
        m_bits[NB-1] = 1'b1;
        m_rem = FRAME;
        m_pos = 0;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("model_tx", tx, (m_rem > 0) ? m_bits[m_pos/CPB] : 1'b1);
      check("model_busy", busy, (m_rem > 0));
      check("model_done", done, m_done);
      check("model_ready", in_ready, (m_rem == 0));
    end
  end

  // Called at a negedge; returns at a negedge a few cycles after the frame ends.
  task automatic run_frame(input logic [DW-1:0] d, input int poke_at,
                           output logic [NB-1:0] line, output int nbusy, output int ndone);
    int guard;
    guard = 0;
    line  = '0;
    nbusy = 0;
    ndone = 0;
    in_data  = d;
    in_valid = 1'b1;
    while (!in_ready && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    check("handshake_wait", (guard < 200), 1);
    @(negedge clk);
    in_valid = 1'b0;
    for (int k = 0; k < FRAME + 4; k++) begin
      if (k < FRAME && (k % CPB) == 0) line[k/CPB] = tx;
      nbusy += int'(busy);
      ndone += int'(done);
      if (k == poke_at) begin
        in_valid = 1'b1;
        in_data  = 8'hFF;
      end
      if (k == poke_at + 2) in_valid = 1'b0;
      @(negedge clk);
    end
  endtask

  logic [NB-1:0] line, l1, l2;
  int            nbusy, ndone, guard;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    // Reset then idle
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (10) @(negedge clk);
    check("idle_tx", tx, 1);
    check("idle_busy", busy, 0);
    check("idle_done", done, 0);
    check("idle_ready", in_ready, 1);

    // Single frame, even parity 0
    run_frame(8'hA5, -10, line, nbusy, ndone);
    check("A5_line", line, 11'b10101001010);
    check("A5_busy_cycles", nbusy, FRAME);
    check("A5_done_pulses", ndone, 1);

    // Odd number of ones -> parity bit 1
    run_frame(8'h07, -10, line, nbusy, ndone);
    check("07_line", line, 11'b11000001110);
    check("07_done_pulses", ndone, 1);

    // Back-to-back with in_valid held high
    in_data  = 8'h3C;
    in_valid = 1'b1;
    guard = 0;
    while (!in_ready && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    check("b2b_handshake_wait", (guard < 200), 1);
    @(negedge clk);
    in_data = 8'hC3;
    l1 = '0;
    l2 = '0;
    for (int k = 0; k < 2 * FRAME + 5; k++) begin
      if (k < FRAME && (k % CPB) == 0) l1[k/CPB] = tx;
      if (k > FRAME && ((k - FRAME - 1) % CPB) == 0 && ((k - FRAME - 1) / CPB) < NB)
        l2[(k-FRAME-1)/CPB] = tx;
      if (k == FRAME) begin
        check("b2b_gap_tx", tx, 1);
        check("b2b_gap_done", done, 1);
        check("b2b_gap_ready", in_ready, 1);
      end
      if (k == FRAME + 1) begin
        check("b2b_second_start", tx, 0);
        in_valid = 1'b0;
      end
      @(negedge clk);
    end
    check("b2b_3C_line", l1, 11'b10001111000);
    check("b2b_C3_line", l2, 11'b10110000110);

    // in_valid while busy is ignored
    run_frame(8'h00, 10, line, nbusy, ndone);
    check("ignore_00_line", line, 11'b10000000000);
    check("ignore_busy_cycles", nbusy, FRAME);
    check("ignore_done_pulses", ndone, 1);
    repeat (8) @(negedge clk);
    check("ignore_no_second_frame", busy, 0);

    // Reset during data bit 3 of 8'hA5
    in_data  = 8'hA5;
    in_valid = 1'b1;
    guard = 0;
    while (!in_ready && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    check("rst_handshake_wait", (guard < 200), 1);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (17) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("rst_tx", tx, 1);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_ready", in_ready, 1);
    rst = 1'b0;
    ndone = 0;
    repeat (FRAME) begin
      @(negedge clk);
      ndone += int'(done);
    end
    check("rst_no_done", ndone, 0);

    run_frame(8'h5A, -10, line, nbusy, ndone);
    check("5A_line", line, 11'b10010110100);
    check("5A_done_pulses", ndone, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
